case3_frame_rx: RTL and testbench

CASE3_FRAME_RX -- requirements
Module: case3_frame_rx

---
 rtl/case3_frame_rx.sv | 136 +++++++++++++
 tb/tb_case3_frame_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/case3_frame_rx.sv
// Serial frame receiver: start bit, 7 data bits (MSB first), 3 code bits and
// a stop bit. The received code is checked against the recomputed code. The
// word is held on a valid/ready output with framing-error and overrun pulses.
module case3_frame_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic       sin,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [6:0] out_data,
  output logic       out_code_err,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, DATA, CODE, STOP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  shreg_q, shreg_d;
  logic        out_valid_q, out_valid_d;
  logic [6:0]  out_data_q, out_data_d;
  logic        out_code_err_q, out_code_err_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        frame_done;
  logic        frame_bad;
  logic [2:0]  code_calc;

  // Code {x,y,z} that a transmitter would attach to data {a..g}
  function automatic logic [2:0] calc_code(input logic [6:0] d);
    logic a, b, c, dd, e, f, g;
    {a, b, c, dd, e, f, g} = d;
    calc_code[2] = a & b & c & dd & e;
    calc_code[1] = (dd ^ e ^ f ^ g) | b | c | (b ^ dd ^ f);
    calc_code[0] = c ^ dd ^ (c & e & g) ^ (a & b & e & g);
  endfunction

  // Next-state, shift/count and output-holding logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_code_err_d = out_code_err_q;
    frame_err_d    = 1'b0;
    overrun_d      = 1'b0;
    frame_done     = 1'b0;
    frame_bad      = 1'b0;
    code_calc      = calc_code(shreg_q[9:3]);

    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d = DATA;
            cnt_d   = 4'd0;
          end
        end
        DATA: begin
          shreg_d = {shreg_q[8:0], sin};
          if (cnt_q == 4'd6) begin
            cnt_d   = 4'd0;
            state_d = CODE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        CODE: begin
          shreg_d = {shreg_q[8:0], sin};
          if (cnt_q == 4'd2) begin
            cnt_d   = 4'd0;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        STOP: begin
          frame_done = sin;
          frame_bad  = !sin;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Consumer pop happens first so a same-cycle frame can refill the slot
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d    = 1'b1;
        out_data_d     = shreg_q[9:3];
        out_code_err_d = (shreg_q[2:0] != code_calc);
      end else begin
        overrun_d = 1'b1;
      end
    end

    frame_err_d = frame_bad;
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      shreg_q        <= 10'd0;
      out_valid_q    <= 1'b0;
      out_data_q     <= 7'h00;
      out_code_err_q <= 1'b0;
      frame_err_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_code_err_q <= out_code_err_d;
      frame_err_q    <= frame_err_d;
      overrun_q      <= overrun_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_code_err = out_code_err_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_case3_frame_rx.sv
// Bench for case3_frame_rx: a frame-level reference model plus directed frames
// with hand-computed expectations.
module tb_case3_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic       sin = 1'b1;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [6:0] out_data;
  logic       out_code_err;
  logic       frame_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;
  bit running = 1'b1;

  case3_frame_rx dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_code_err(out_code_err),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: collect 12 strobed samples after a start bit, then judge
  // the whole frame at once.
  int         m_nsamp;
  logic [11:0] m_word;
  logic       exp_valid, exp_cerr, exp_ferr, exp_ovr;
  logic [6:0] exp_data;

  function automatic logic [2:0] spec_code(input logic [6:0] w);
    logic a, b, c, d, e, f, g, x, y, z;
    {a, b, c, d, e, f, g} = w;
    x = a & b & c & d & e;
    y = (d ^ e ^ f ^ g) | b | c | (b ^ d ^ f);
    z = c ^ d ^ (c & e & g) ^ (a & b & e & g);
    return {x, y, z};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_nsamp = 0; m_word = '0;
      exp_valid = 0; exp_data = 0; exp_cerr = 0; exp_ferr = 0; exp_ovr = 0;
    end else begin
      logic held;
      held = exp_valid;
      exp_ferr = 0;
      exp_ovr  = 0;
      if (exp_valid && out_ready) exp_valid = 0;
      if (bit_en) begin
        if (m_nsamp == 0) begin
          if (!sin) begin m_word = 12'd0; m_nsamp = 1; end
        end else begin
          m_word = {m_word[10:0], sin};
          m_nsamp++;
          if (m_nsamp == 12) begin
            m_nsamp = 0;
            if (!m_word[0]) exp_ferr = 1;
            else if (held && !out_ready) exp_ovr = 1;
            else begin
              exp_valid = 1;
              exp_data  = m_word[10:4];
              exp_cerr  = (m_word[3:1] != spec_code(m_word[10:4]));
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (running) begin
      n_tests++;
      if ({out_valid, out_data, out_code_err, frame_err, overrun} !==
          {exp_valid, exp_data, exp_cerr, exp_ferr, exp_ovr}) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got v=%b d=%h ce=%b fe=%b ov=%b want v=%b d=%h ce=%b fe=%b ov=%b",
                 $time, out_valid, out_data, out_code_err, frame_err, overrun,
                 exp_valid, exp_data, exp_cerr, exp_ferr, exp_ovr);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  // Drive one 12-bit frame (bit 11 first), strobing every per-th cycle; on
  // non-strobe cycles sin carries the inverse of the current bit as a glitch.
  task automatic send(input logic [11:0] fr, input int per, input bit rdy_at_stop);
    for (int i = 11; i >= 0; i--) begin
      for (int k = 0; k < per; k++) begin
        @(negedge clk);
        bit_en = (k == per - 1);
        sin    = bit_en ? fr[i] : ~fr[i];
        if (i == 0 && bit_en && rdy_at_stop) out_ready = 1'b1;
      end
    end
    @(negedge clk);
    bit_en = 1'b0; sin = 1'b1; out_ready = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    check("pop_clears_valid", {7'd0, out_valid}, 8'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bit_en = 1'b1; sin = 1'b1;
    end
    @(negedge clk); bit_en = 1'b0;
  endtask

  initial begin
    logic [11:0] f7f, f4d, f4d_bad, fbad, f00;
    f7f     = {1'b0, 7'h7F, 3'b110, 1'b1};
    f4d     = {1'b0, 7'h4D, 3'b011, 1'b1};
    f4d_bad = {1'b0, 7'h4D, 3'b111, 1'b1};
    fbad    = {1'b0, 7'h00, 3'b000, 1'b0};
    f00     = {1'b0, 7'h00, 3'b000, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_valid", {7'd0, out_valid}, 8'd0);
    check("reset_data", {1'b0, out_data}, 8'h00);
    check("reset_pulses", {5'd0, out_code_err, frame_err, overrun}, 8'd0);
    @(posedge clk); #2 rst = 1'b0;
    idle(2);

    // Model pins against hand-computed codes
    check("model_code_7f", {5'd0, spec_code(7'h7F)}, 8'b110);
    check("model_code_4d", {5'd0, spec_code(7'h4D)}, 8'b011);

    // Back-to-back strobes, all-ones data
    send(f7f, 1, 0);
    check("f7f_valid", {7'd0, out_valid}, 8'd1);
    check("f7f_data", {1'b0, out_data}, 8'h7F);
    check("f7f_cerr", {7'd0, out_code_err}, 8'd0);
    check("f7f_model_data", {1'b0, exp_data}, 8'h7F);
    pop();

    send(f4d, 1, 0);
    check("f4d_data", {1'b0, out_data}, 8'h4D);
    check("f4d_cerr", {7'd0, out_code_err}, 8'd0);
    pop();
    send(f4d_bad, 1, 0);
    check("f4d_bad_valid", {7'd0, out_valid}, 8'd1);
    check("f4d_bad_data", {1'b0, out_data}, 8'h4D);
    check("f4d_bad_cerr", {7'd0, out_code_err}, 8'd1);
    pop();

    // Bad stop bit
    send(fbad, 1, 0);
    check("ferr_pulse", {7'd0, frame_err}, 8'd1);
    check("ferr_no_valid", {7'd0, out_valid}, 8'd0);
    check("ferr_no_ovr", {7'd0, overrun}, 8'd0);
    @(negedge clk);
    check("ferr_one_cycle", {7'd0, frame_err}, 8'd0);

    // Overrun while word held
    send(f7f, 1, 0);
    check("ovr_first_valid", {7'd0, out_valid}, 8'd1);
    send(f00, 1, 0);
    check("ovr_pulse", {7'd0, overrun}, 8'd1);
    check("ovr_keeps_data", {1'b0, out_data}, 8'h7F);
    check("ovr_keeps_valid", {7'd0, out_valid}, 8'd1);
    @(negedge clk);
    check("ovr_one_cycle", {7'd0, overrun}, 8'd0);
    pop();

    // Frame completes on the same cycle the held word is taken
    send(f7f, 1, 0);
    send(f4d, 1, 1);
    check("swap_valid", {7'd0, out_valid}, 8'd1);
    check("swap_data", {1'b0, out_data}, 8'h4D);
    check("swap_no_ovr", {7'd0, overrun}, 8'd0);
    pop();

    // Sparse strobes with glitches in idle and between strobes
    repeat (3) begin @(negedge clk); bit_en = 1'b0; sin = 1'b0; end
    @(negedge clk); bit_en = 1'b1; sin = 1'b1;
    send(f7f, 4, 0);
    check("sparse_valid", {7'd0, out_valid}, 8'd1);
    check("sparse_data", {1'b0, out_data}, 8'h7F);
    check("sparse_cerr", {7'd0, out_code_err}, 8'd0);
    pop();

    // Reset after five data bits
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); bit_en = 1'b1; sin = (i == 0) ? 1'b0 : 1'b1;
    end
    @(posedge clk); #2 rst = 1'b1; bit_en = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {out_valid, out_data}, 8'h00);
    check("midrst_pulses", {5'd0, out_code_err, frame_err, overrun}, 8'd0);
    @(posedge clk); #2 rst = 1'b0;
    idle(8);
    check("postrst_no_valid", {7'd0, out_valid}, 8'd0);
    send(f00, 1, 0);
    check("postrst_valid", {7'd0, out_valid}, 8'd1);
    check("postrst_data", {1'b0, out_data}, 8'h00);
    check("postrst_cerr", {7'd0, out_code_err}, 8'd0);
    pop();

    @(negedge clk);
    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
